video_pattern_gen: RTL and testbench

- Parametrised video timing and test-pattern generator. Next generation of the fixed 640x480 checkerboard VGA block.
- Programmable porch, sync and active timing; sync polarity; pixel clock-enable divider.
- Four runtime-selectable patterns; mode changes take effect only at a frame boundary.
- Drives CLK_VIDEO/CE_PIXEL/VGA_* in emu directly. Mode select comes from an OSD status field.

---
 rtl/video_pattern_gen.sv | 154 +++++++++++++++
 tb/tb_video_pattern_gen.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: programmable video timing and four-pattern test image generator
//   clk_sys     in   core clock, the only clock
//   reset       in   synchronous active-high reset
//   mode        in   pattern select, latched at each frame start
//   ce_pix      out  pixel clock enable, one cycle in CE_DIV
//   hcount      out  current pixel x
//   vcount      out  current line y
//   hblank      out  outside the active columns
//   vblank      out  outside the active lines
//   de          out  active area
//   hs, vs      out  syncs, active level HS_POL / VS_POL
//   r, g, b     out  pixel colour, zero outside the active area
//   frame_start out  one-cycle pulse when the counters wrap to (0,0)
module video_pattern_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int CE_DIV     = 1,
    parameter int CHECK_LOG2 = 5,
    parameter int FRAME_LOG2 = 6
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [1:0] mode,
    output logic       ce_pix,
    output logic [11:0] hcount,
    output logic [11:0] vcount,
    output logic       hblank,
    output logic       vblank,
    output logic       de,
    output logic       hs,
    output logic       vs,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic       frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FW = FRAME_LOG2 + 2;
    localparam logic [3:0] DIV_MAX = 4'(CE_DIV - 1);
    localparam logic [11:0] H_MAX = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_MAX = 12'(V_TOTAL - 1);
    localparam logic [11:0] SUB_MAX = 12'(H_ACTIVE / 8 - 1);
    // 13-bit bounds so a sync that ends exactly at the total (4096) still compares correctly
    localparam logic [12:0] HA = 13'(H_ACTIVE);
    localparam logic [12:0] HS_B = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_E = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] VA = 13'(V_ACTIVE);
    localparam logic [12:0] VS_B = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_E = 13'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic HS_ON = 1'(HS_POL != 0);
    localparam logic VS_ON = 1'(VS_POL != 0);

    if (H_TOTAL > 4096 || V_TOTAL > 4096 || H_ACTIVE % 8 != 0 || CE_DIV < 1 || CE_DIV > 16) begin : g_bad_params
        $error("video_pattern_gen: illegal parameter set");
    end

    logic [3:0]    div_q, div_d;
    logic          ce_q, adv;
    logic [11:0]   hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [11:0]   sub_q, sub_d;
    logic [2:0]    bar_q, bar_d;
    logic [1:0]    mode_q, mode_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [1:0]    cs;
    logic          fs_q, fs_d;
    logic          hbl_q, hbl_d, vbl_q, vbl_d, de_q, de_d, hs_q, hs_d, vs_q, vs_d;
    logic          chk;
    logic [23:0]   pat, rgb_q, rgb_d;

    always_comb begin
        adv = div_q == DIV_MAX;
        div_d = adv ? 4'd0 : div_q + 4'd1;
        hcnt_d = !adv ? hcnt_q : (hcnt_q == H_MAX) ? 12'd0 : hcnt_q + 12'd1;
        vcnt_d = !(adv && hcnt_q == H_MAX) ? vcnt_q : (vcnt_q == V_MAX) ? 12'd0 : vcnt_q + 12'd1;
        fs_d = adv && hcnt_d == 12'd0 && vcnt_d == 12'd0;
        mode_d = fs_d ? mode : mode_q;
        fcnt_d = fcnt_q + FW'(fs_d);
        // bar index tracks hcount / (H_ACTIVE/8) with a sub-counter instead of a divider
        sub_d = !adv ? sub_q : (hcnt_d == 12'd0 || sub_q == SUB_MAX) ? 12'd0 : sub_q + 12'd1;
        bar_d = !adv ? bar_q : (hcnt_d == 12'd0) ? 3'd0 : bar_q + 3'(sub_q == SUB_MAX);
        hbl_d = {1'b0, hcnt_d} >= HA;
        vbl_d = {1'b0, vcnt_d} >= VA;
        de_d = !hbl_d && !vbl_d;
        hs_d = ({1'b0, hcnt_d} >= HS_B && {1'b0, hcnt_d} < HS_E) ? HS_ON : !HS_ON;
        vs_d = ({1'b0, vcnt_d} >= VS_B && {1'b0, vcnt_d} < VS_E) ? VS_ON : !VS_ON;
        chk = hcnt_d[CHECK_LOG2] ^ vcnt_d[CHECK_LOG2];
        cs = fcnt_d[FRAME_LOG2 +: 2];
        // bar colours: red off for index bit1, green off for bit2, blue off for bit0
        pat = (mode_d == 2'd0) ? (chk ? 24'h000000 : 24'hFFFFFF) :
              (mode_d == 2'd1) ? {{8{~bar_d[1]}}, {8{~bar_d[2]}}, {8{~bar_d[0]}}} :
              (mode_d == 2'd2) ? {3{hcnt_d[7:0]}} :
              {{8{cs == 2'd0 || cs == 2'd3}}, {8{cs == 2'd1 || cs == 2'd3}}, {8{cs[1]}}};
        rgb_d = de_d ? pat : 24'h000000;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            div_q  <= 4'd0;
            ce_q   <= 1'b0;
            hcnt_q <= H_MAX;
            vcnt_q <= V_MAX;
            sub_q  <= 12'd0;
            bar_q  <= 3'd0;
            mode_q <= 2'd0;
            fcnt_q <= '1;
            fs_q   <= 1'b0;
            hbl_q  <= 1'b1;
            vbl_q  <= 1'b1;
            de_q   <= 1'b0;
            hs_q   <= !HS_ON;
            vs_q   <= !VS_ON;
            rgb_q  <= 24'h000000;
        end else begin
            div_q  <= div_d;
            ce_q   <= adv;
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            sub_q  <= sub_d;
            bar_q  <= bar_d;
            mode_q <= mode_d;
            fcnt_q <= fcnt_d;
            fs_q   <= fs_d;
            // pixel outputs load only with the counters so they hold between enables
            if (adv) begin
                hbl_q <= hbl_d;
                vbl_q <= vbl_d;
                de_q  <= de_d;
                hs_q  <= hs_d;
                vs_q  <= vs_d;
                rgb_q <= rgb_d;
            end
        end
    end

    assign ce_pix = ce_q;
    assign hcount = hcnt_q;
    assign vcount = vcnt_q;
    assign hblank = hbl_q;
    assign vblank = vbl_q;
    assign de = de_q;
    assign hs = hs_q;
    assign vs = vs_q;
    assign {r, g, b} = rgb_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: random-stimulus check of three video_pattern_gen configurations against an arithmetic model
module tb_video_pattern_gen;
    typedef struct {
        int ha, hfp, hsy, hbp, va, vfp, vsy, vbp, hp, vp, d, cl, fl;
    } cfg_t;
    typedef struct packed {
        logic ce;
        logic [11:0] h;
        logic [11:0] v;
        logic hb, vb, de, hs, vs;
        logic [23:0] rgb;
        logic fs;
    } out_t;

    logic clk = 1'b0;
    logic rst0, rst1;
    logic [1:0] mode;
    int vectors = 0;
    int errors = 0;
    int cur = 0;
    int k [3] = '{0, 0, 0};
    logic [1:0] mm [3] = '{2'd0, 2'd0, 2'd0};
    cfg_t cf [3];
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    logic [23:0] solids [4] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF};

    always #5 clk = ~clk;

    logic ce0, hb0, vb0, de0, hs0, vs0, fs0, ce1, hb1, vb1, de1, hs1, vs1, fs1, ce2, hb2, vb2, de2, hs2, vs2, fs2;
    logic [11:0] h0, v0, h1, v1, h2, v2;
    logic [7:0] r0, g0c, b0, r1, g1c, b1, r2, g2c, b2;
    out_t o0, o1, o2;
    assign o0 = {ce0, h0, v0, hb0, vb0, de0, hs0, vs0, r0, g0c, b0, fs0};
    assign o1 = {ce1, h1, v1, hb1, vb1, de1, hs1, vs1, r1, g1c, b1, fs1};
    assign o2 = {ce2, h2, v2, hb2, vb2, de2, hs2, vs2, r2, g2c, b2, fs2};

    video_pattern_gen u0 (
        .clk_sys(clk), .reset(rst0), .mode(mode), .ce_pix(ce0), .hcount(h0), .vcount(v0),
        .hblank(hb0), .vblank(vb0), .de(de0), .hs(hs0), .vs(vs0), .r(r0), .g(g0c), .b(b0), .frame_start(fs0));

    video_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1), .VS_POL(0), .CE_DIV(4), .CHECK_LOG2(2), .FRAME_LOG2(0)
    ) u1 (
        .clk_sys(clk), .reset(rst1), .mode(mode), .ce_pix(ce1), .hcount(h1), .vcount(v1),
        .hblank(hb1), .vblank(vb1), .de(de1), .hs(hs1), .vs(vs1), .r(r1), .g(g1c), .b(b1), .frame_start(fs1));

    video_pattern_gen #(
        .H_ACTIVE(16), .H_FP(1), .H_SYNC(2), .H_BP(0), .V_ACTIVE(6), .V_FP(0), .V_SYNC(1), .V_BP(0),
        .HS_POL(0), .VS_POL(1), .CE_DIV(1), .CHECK_LOG2(1), .FRAME_LOG2(1)
    ) u2 (
        .clk_sys(clk), .reset(rst1), .mode(mode), .ce_pix(ce2), .hcount(h2), .vcount(v2),
        .hblank(hb2), .vblank(vb2), .de(de2), .hs(hs2), .vs(vs2), .r(r2), .g(g2c), .b(b2), .frame_start(fs2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            if (errors <= 20)
                $display("FAIL dut%0d %s: got %0h expected %0h at %0t", cur, tag, got, exp, $time);
        end
    endtask

    // k = clock edges since reset was released; pixel n = k/CE_DIV - 1
    function automatic out_t model(input cfg_t c, input int kk, input logic [1:0] m);
        out_t o;
        int ht, vt, n, h, v, f;
        ht = c.ha + c.hfp + c.hsy + c.hbp;
        vt = c.va + c.vfp + c.vsy + c.vbp;
        n = kk / c.d - 1;
        o.ce = kk > 0 && kk % c.d == 0;
        if (n < 0) begin
            o.h = 12'(ht - 1);
            o.v = 12'(vt - 1);
            o.hb = 1'b1;
            o.vb = 1'b1;
            o.de = 1'b0;
            o.hs = !c.hp;
            o.vs = !c.vp;
            o.rgb = 24'h0;
            o.fs = 1'b0;
            return o;
        end
        h = n % ht;
        v = (n / ht) % vt;
        f = n / (ht * vt);
        o.h = 12'(h);
        o.v = 12'(v);
        o.hb = h >= c.ha;
        o.vb = v >= c.va;
        o.de = !o.hb && !o.vb;
        o.hs = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsy) ? (c.hp != 0) : (c.hp == 0);
        o.vs = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vsy) ? (c.vp != 0) : (c.vp == 0);
        o.fs = o.ce && h == 0 && v == 0;
        if (!o.de) o.rgb = 24'h0;
        else if (m == 2'd0) o.rgb = (((h >> c.cl) ^ (v >> c.cl)) & 1) != 0 ? 24'h000000 : 24'hFFFFFF;
        else if (m == 2'd1) o.rgb = bars[h / (c.ha / 8)];
        else if (m == 2'd2) o.rgb = {3{8'(h % 256)}};
        else o.rgb = solids[(f >> c.fl) % 4];
        return o;
    endfunction

    task automatic step();
        out_t e;
        out_t o [3];
        o[0] = o0;
        o[1] = o1;
        o[2] = o2;
        for (int i = 0; i < 3; i++) begin
            cur = i;
            if ((i == 0) ? rst0 : rst1) k[i] = 0;
            else k[i]++;
            e = model(cf[i], k[i], mm[i]);
            if (e.fs) begin
                mm[i] = mode;
                e = model(cf[i], k[i], mm[i]);
            end
            check("ce_pix", 32'(o[i].ce), 32'(e.ce));
            check("hcount", 32'(o[i].h), 32'(e.h));
            check("vcount", 32'(o[i].v), 32'(e.v));
            check("hblank", 32'(o[i].hb), 32'(e.hb));
            check("vblank", 32'(o[i].vb), 32'(e.vb));
            check("de", 32'(o[i].de), 32'(e.de));
            check("hs", 32'(o[i].hs), 32'(e.hs));
            check("vs", 32'(o[i].vs), 32'(e.vs));
            check("rgb", 32'(o[i].rgb), 32'(e.rgb));
            check("frame_start", 32'(o[i].fs), 32'(e.fs));
        end
    endtask

    initial begin
        cf[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 1, 5, 6};
        cf[1] = '{16, 2, 3, 3, 8, 1, 2, 1, 1, 0, 4, 2, 0};
        cf[2] = '{16, 1, 2, 0, 6, 0, 1, 0, 0, 1, 1, 1, 1};
        rst0 = 1'b1;
        rst1 = 1'b1;
        mode = 2'd0;
        // each segment restarts the full-size DUT with a new pattern; the small DUTs see random resets and mode changes
        for (int s = 0; s < 4; s++) begin
            for (int t = 0; t < ((s == 0) ? 26500 : 1200); t++) begin
                @(negedge clk);
                step();
                rst0 = t < 2;
                rst1 = (s == 0 && t < 2) || $urandom_range(2999) == 0;
                if (t < 3) mode = 2'(s);
                else if ($urandom_range(199) == 0) mode = 2'($urandom_range(3));
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
